// File: rtl/soin_gshare_predictor_if.sv
// Fetch / execute / debug bundle for the gshare direction predictor.
// The master side is fetch+execute+debug host; the slave side is the predictor.
interface soin_gshare_predictor_if #(
    parameter int HIST_W  = 8,
    parameter int INDEX_W = 10
);
    localparam int META_W = HIST_W + INDEX_W + 1;

    logic              bpredictor_ready;
    logic              soin_bpredictor_stall;

    logic              fetch_bpredictor_lookup;
    logic [31:0]       fetch_bpredictor_PC;
    logic              fetch_bpredictor_is_cond;
    logic              bpredictor_fetch_valid;
    logic              bpredictor_fetch_p_dir;
    logic [META_W-1:0] bpredictor_fetch_meta;

    logic              execute_bpredictor_update;
    logic              execute_bpredictor_dir;
    logic              execute_bpredictor_miss;
    logic [META_W-1:0] execute_bpredictor_meta;

    logic [1:0]        soin_bpredictor_debug_sel;
    logic [31:0]       bpredictor_soin_debug;

    modport master (
        input  bpredictor_ready,
        output soin_bpredictor_stall,
        output fetch_bpredictor_lookup,
        output fetch_bpredictor_PC,
        output fetch_bpredictor_is_cond,
        input  bpredictor_fetch_valid,
        input  bpredictor_fetch_p_dir,
        input  bpredictor_fetch_meta,
        output execute_bpredictor_update,
        output execute_bpredictor_dir,
        output execute_bpredictor_miss,
        output execute_bpredictor_meta,
        output soin_bpredictor_debug_sel,
        input  bpredictor_soin_debug
    );

    modport slave (
        output bpredictor_ready,
        input  soin_bpredictor_stall,
        input  fetch_bpredictor_lookup,
        input  fetch_bpredictor_PC,
        input  fetch_bpredictor_is_cond,
        output bpredictor_fetch_valid,
        output bpredictor_fetch_p_dir,
        output bpredictor_fetch_meta,
        input  execute_bpredictor_update,
        input  execute_bpredictor_dir,
        input  execute_bpredictor_miss,
        input  execute_bpredictor_meta,
        input  soin_bpredictor_debug_sel,
        output bpredictor_soin_debug
    );
endinterface

// File: rtl/soin_gshare_predictor.sv
// Parametrised gshare direction predictor.
// Self-initialising counter table, speculative global history with miss repair,
// two-stage counter training pipe with same-index forwarding, saturating debug counters.
module soin_gshare_predictor #(
    parameter int          HIST_W   = 8,
    parameter int          INDEX_W  = 10,
    parameter int          CTR_W    = 2,
    parameter int unsigned INIT_CTR = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    soin_gshare_predictor_if.slave  bp
);
    localparam int META_W  = HIST_W + INDEX_W + 1;
    localparam int ENTRIES = 1 << INDEX_W;

    typedef logic [CTR_W-1:0]   ctr_t;
    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [HIST_W-1:0]  ghr_t;

    localparam ctr_t CTR_MAX  = '1;
    localparam ctr_t CTR_INIT = ctr_t'(INIT_CTR);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    // Shift one outcome into a history register (youngest outcome in bit 0).
    function automatic ghr_t shift_in(input ghr_t hist, input logic outcome);
        return ghr_t'({hist, outcome});
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

    state_t state_q;
    idx_t   init_ptr_q;
    logic   ready_q;

    ctr_t   table_q [ENTRIES];

    ghr_t              ghr_q;
    logic              valid_q;
    logic              p_dir_q;
    logic [META_W-1:0] meta_q;

    logic   u_vld_q;
    idx_t   u_idx_q;
    logic   u_dir_q;
    ctr_t   u_rdata_q;
    logic   fwd_vld_q;
    idx_t   fwd_idx_q;
    ctr_t   fwd_ctr_q;

    logic [31:0] lookups_q;
    logic [31:0] updates_q;
    logic [31:0] misses_q;

    logic stall;
    logic lookup_acc;
    idx_t lookup_idx;
    logic lookup_p_dir;
    logic update_acc;
    logic update_miss;
    ghr_t upd_ghr;
    idx_t upd_idx;
    ctr_t u_old;
    ctr_t u_new;

    assign stall        = bp.soin_bpredictor_stall;
    assign lookup_acc   = bp.fetch_bpredictor_lookup & ~stall & ready_q;
    assign lookup_idx   = bp.fetch_bpredictor_PC[INDEX_W+1:2] ^ idx_t'(ghr_q);
    assign lookup_p_dir = table_q[lookup_idx][CTR_W-1];
    assign update_acc   = bp.execute_bpredictor_update & ready_q;
    assign update_miss  = update_acc & bp.execute_bpredictor_miss;
    assign upd_ghr      = bp.execute_bpredictor_meta[META_W-1 -: HIST_W];
    assign upd_idx      = bp.execute_bpredictor_meta[INDEX_W:1];

    // PC bits outside the index field and the returned p_dir bit carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{bp.fetch_bpredictor_PC[31:INDEX_W+2],
                             bp.fetch_bpredictor_PC[1:0],
                             bp.execute_bpredictor_meta[0]};

    // Init sequencer: sweep every entry once after reset, then declare ready.
    // NOTE: every clocked block uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + idx_t'(1);
                    if (init_ptr_q == '1) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table write port: init sweep, otherwise the U2 training write.
    // NOTE: the counter array is not reset; the init sweep gives it defined contents instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            table_q[init_ptr_q] <= CTR_INIT;
        end else if (u_vld_q) begin
            table_q[u_idx_q] <= u_new;
        end
    end

    // Lookup response registers; a stall freezes them completely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            p_dir_q <= 1'b0;
            meta_q  <= '0;
        end else if (!stall) begin
            if (lookup_acc) begin
                valid_q <= 1'b1;
                p_dir_q <= lookup_p_dir;
                meta_q  <= {ghr_q, lookup_idx, lookup_p_dir};
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // Speculative history: repair from execute wins over the fetch-side shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (update_miss) begin
            ghr_q <= shift_in(upd_ghr, bp.execute_bpredictor_dir);
        end else if (valid_q && bp.fetch_bpredictor_is_cond && !stall) begin
            ghr_q <= shift_in(ghr_q, p_dir_q);
        end
    end

    // U2 read-modify-write: the previous U2 result bypasses the RAM when it hit the same entry.
    always_comb begin
        u_old = (fwd_vld_q && (fwd_idx_q == u_idx_q)) ? fwd_ctr_q : u_rdata_q;
        if (u_dir_q) begin
            u_new = (u_old == CTR_MAX) ? u_old : u_old + ctr_t'(1);
        end else begin
            u_new = (u_old == '0) ? u_old : u_old - ctr_t'(1);
        end
    end

    // Training pipe: U1 latches the update and reads the counter, U2 result is kept for forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u_vld_q   <= 1'b0;
            u_idx_q   <= '0;
            u_dir_q   <= 1'b0;
            u_rdata_q <= '0;
            fwd_vld_q <= 1'b0;
            fwd_idx_q <= '0;
            fwd_ctr_q <= '0;
        end else begin
            u_vld_q <= update_acc;
            if (update_acc) begin
                u_idx_q   <= upd_idx;
                u_dir_q   <= bp.execute_bpredictor_dir;
                u_rdata_q <= table_q[upd_idx];
            end
            fwd_vld_q <= u_vld_q;
            if (u_vld_q) begin
                fwd_idx_q <= u_idx_q;
                fwd_ctr_q <= u_new;
            end
        end
    end

    // Saturating event counters for debug visibility.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_q <= '0;
            updates_q <= '0;
            misses_q  <= '0;
        end else begin
            if (lookup_acc)  lookups_q <= sat_inc32(lookups_q);
            if (update_acc)  updates_q <= sat_inc32(updates_q);
            if (update_miss) misses_q  <= sat_inc32(misses_q);
        end
    end

    // Debug read mux.
    // NOTE: the output gets a default first so no path through the block can infer a latch.
    always_comb begin
        bp.bpredictor_soin_debug = '0;
        case (bp.soin_bpredictor_debug_sel)
            2'd0:    bp.bpredictor_soin_debug = lookups_q;
            2'd1:    bp.bpredictor_soin_debug = updates_q;
            2'd2:    bp.bpredictor_soin_debug = misses_q;
            default: bp.bpredictor_soin_debug = 32'(ghr_q);
        endcase
    end

    assign bp.bpredictor_ready       = ready_q;
    assign bp.bpredictor_fetch_valid = valid_q;
    assign bp.bpredictor_fetch_p_dir = p_dir_q;
    assign bp.bpredictor_fetch_meta  = meta_q;

endmodule

// File: tb/tb_soin_gshare_predictor.sv
// Directed bench for soin_gshare_predictor (HIST_W=8, INDEX_W=10, CTR_W=2, INIT_CTR=1).
module tb_soin_gshare_predictor;
    localparam int HIST_W  = 8;
    localparam int INDEX_W = 10;
    localparam int META_W  = HIST_W + INDEX_W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    soin_gshare_predictor_if #(.HIST_W(HIST_W), .INDEX_W(INDEX_W)) bp ();

    soin_gshare_predictor #(
        .HIST_W(HIST_W), .INDEX_W(INDEX_W), .CTR_W(2), .INIT_CTR(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_lookups = 0;
    int exp_updates = 0;
    int exp_misses  = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [META_W-1:0] mk_meta(input logic [7:0] ghr, input logic [9:0] idx, input logic p);
        return {ghr, idx, p};
    endfunction

    task automatic check_dbg(input string tag, input logic [1:0] sel, input logic [31:0] expected);
        bp.soin_bpredictor_debug_sel = sel;
        #1;
        check(tag, bp.bpredictor_soin_debug, expected);
    endtask

    task automatic check_resp(input string tag, input logic v, input logic p, input logic [META_W-1:0] m);
        check({tag, "_valid"}, 32'(bp.bpredictor_fetch_valid), 32'(v));
        check({tag, "_pdir"},  32'(bp.bpredictor_fetch_p_dir), 32'(p));
        check({tag, "_meta"},  32'(bp.bpredictor_fetch_meta),  32'(m));
    endtask

    // One accepted lookup, response check, then one response cycle with is_cond = cond.
    task automatic lookup_chk(input string tag, input logic [31:0] pc, input logic cond,
                              input logic exp_p, input logic [META_W-1:0] exp_meta);
        bp.fetch_bpredictor_lookup = 1'b1;
        bp.fetch_bpredictor_PC     = pc;
        tick();
        bp.fetch_bpredictor_lookup = 1'b0;
        exp_lookups++;
        check_resp(tag, 1'b1, exp_p, exp_meta);
        bp.fetch_bpredictor_is_cond = cond;
        tick();
        bp.fetch_bpredictor_is_cond = 1'b0;
    endtask

    task automatic upd_drive(input logic dir, input logic miss, input logic [META_W-1:0] meta);
        bp.execute_bpredictor_update = 1'b1;
        bp.execute_bpredictor_dir    = dir;
        bp.execute_bpredictor_miss   = miss;
        bp.execute_bpredictor_meta   = meta;
        exp_updates++;
        if (miss) exp_misses++;
    endtask

    task automatic upd_clear();
        bp.execute_bpredictor_update = 1'b0;
        bp.execute_bpredictor_miss   = 1'b0;
    endtask

    // Counts edges after reset release; ready must rise exactly on edge 1024, valid stays low.
    task automatic run_init(input string tag);
        int early = 0;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            if (i < 1024 && (bp.bpredictor_ready !== 1'b0 || bp.bpredictor_fetch_valid !== 1'b0)) early++;
        end
        check({tag, "_early_ready_or_valid"}, 32'(early), 32'd0);
        check({tag, "_ready"}, 32'(bp.bpredictor_ready), 32'd1);
        check({tag, "_valid_end"}, 32'(bp.bpredictor_fetch_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bp.soin_bpredictor_stall     = 1'b0;
        bp.fetch_bpredictor_lookup   = 1'b0;
        bp.fetch_bpredictor_PC       = '0;
        bp.fetch_bpredictor_is_cond  = 1'b0;
        bp.execute_bpredictor_update = 1'b0;
        bp.execute_bpredictor_dir    = 1'b0;
        bp.execute_bpredictor_miss   = 1'b0;
        bp.execute_bpredictor_meta   = '0;
        bp.soin_bpredictor_debug_sel = 2'd0;

        // 1: reset state, then init sweep with lookups and updates offered (all ignored)
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bp.bpredictor_ready), 32'd0);
        check_resp("rst", 1'b0, 1'b0, '0);
        check_dbg("rst_ghr", 2'd3, 32'd0);
        reset = 1'b0;
        bp.fetch_bpredictor_lookup   = 1'b1;
        bp.fetch_bpredictor_PC       = 32'h100;
        bp.execute_bpredictor_update = 1'b1;
        bp.execute_bpredictor_dir    = 1'b1;
        bp.execute_bpredictor_meta   = mk_meta(8'h00, 10'h040, 1'b0);
        run_init("init");
        bp.fetch_bpredictor_lookup = 1'b0;
        upd_clear();
        check_dbg("init_lookups", 2'd0, 32'd0);
        check_dbg("init_updates", 2'd1, 32'd0);

        // 2: first lookup after init, then idle cycle drops valid
        lookup_chk("t2", 32'h100, 1'b0, 1'b0, mk_meta(8'h00, 10'h040, 1'b0));
        check("t2_idle_valid", 32'(bp.bpredictor_fetch_valid), 32'd0);

        // 3: 1 -> 2 -> 3 -> 3 by back-to-back increments, then 3 -> 2 -> 1 by back-to-back decrements
        repeat (3) begin
            upd_drive(1'b1, 1'b0, mk_meta(8'h00, 10'h040, 1'b0));
            tick();
        end
        upd_clear();
        tick();
        lookup_chk("t3_up", 32'h100, 1'b0, 1'b1, mk_meta(8'h00, 10'h040, 1'b1));
        repeat (2) begin
            upd_drive(1'b0, 1'b0, mk_meta(8'h00, 10'h040, 1'b1));
            tick();
        end
        upd_clear();
        tick();
        lookup_chk("t3_fwd", 32'h100, 1'b0, 1'b0, mk_meta(8'h00, 10'h040, 1'b0));
        check_dbg("t3_updates", 2'd1, 32'(exp_updates));

        // 4: train entry 0x080 to 3, speculative shifts 1,1,0, then miss repair over a shift
        repeat (2) begin
            upd_drive(1'b1, 1'b0, mk_meta(8'h00, 10'h080, 1'b0));
            tick();
        end
        upd_clear();
        tick();
        lookup_chk("t4_l1", 32'h200, 1'b1, 1'b1, mk_meta(8'h00, 10'h080, 1'b1));
        check_dbg("t4_ghr1", 2'd3, 32'h01);
        lookup_chk("t4_l2", 32'h204, 1'b1, 1'b1, mk_meta(8'h01, 10'h080, 1'b1));
        check_dbg("t4_ghr2", 2'd3, 32'h03);
        lookup_chk("t4_l3", 32'h000, 1'b1, 1'b0, mk_meta(8'h03, 10'h003, 1'b0));
        check_dbg("t4_ghr3", 2'd3, 32'h06);
        bp.fetch_bpredictor_lookup = 1'b1;
        bp.fetch_bpredictor_PC     = 32'h000;
        tick();
        bp.fetch_bpredictor_lookup = 1'b0;
        exp_lookups++;
        check_resp("t4_l4", 1'b1, 1'b0, mk_meta(8'h06, 10'h006, 1'b0));
        bp.fetch_bpredictor_is_cond = 1'b1;
        upd_drive(1'b0, 1'b1, mk_meta(8'h01, 10'h003, 1'b0));
        tick();
        bp.fetch_bpredictor_is_cond = 1'b0;
        upd_clear();
        check_dbg("t4_repair_ghr", 2'd3, 32'h02);
        check_dbg("t4_misses", 2'd2, 32'(exp_misses));
        check_dbg("t4_updates", 2'd1, 32'(exp_updates));

        // 5: stall for 3 cycles after a lookup; a new lookup and is_cond are offered but ignored
        tick();
        bp.fetch_bpredictor_lookup = 1'b1;
        bp.fetch_bpredictor_PC     = 32'h208;
        tick();
        exp_lookups++;
        check_resp("t5_resp", 1'b1, 1'b1, mk_meta(8'h02, 10'h080, 1'b1));
        bp.soin_bpredictor_stall    = 1'b1;
        bp.fetch_bpredictor_PC      = 32'h000;
        bp.fetch_bpredictor_is_cond = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_resp($sformatf("t5_hold%0d", k), 1'b1, 1'b1, mk_meta(8'h02, 10'h080, 1'b1));
        end
        check_dbg("t5_ghr", 2'd3, 32'h02);
        check_dbg("t5_lookups", 2'd0, 32'(exp_lookups));
        bp.soin_bpredictor_stall    = 1'b0;
        bp.fetch_bpredictor_lookup  = 1'b0;
        bp.fetch_bpredictor_is_cond = 1'b0;
        tick();
        check("t5_release_valid", 32'(bp.bpredictor_fetch_valid), 32'd0);

        // 6: async reset with a lookup response and an update in flight, then full re-init
        upd_drive(1'b1, 1'b0, mk_meta(8'h00, 10'h080, 1'b0));
        bp.fetch_bpredictor_lookup = 1'b1;
        bp.fetch_bpredictor_PC     = 32'h200;
        tick();
        upd_clear();
        bp.fetch_bpredictor_lookup = 1'b0;
        check("t6_pre_valid", 32'(bp.bpredictor_fetch_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_ready", 32'(bp.bpredictor_ready), 32'd0);
        check_resp("t6_async", 1'b0, 1'b0, '0);
        check_dbg("t6_async_lookups", 2'd0, 32'd0);
        check_dbg("t6_async_ghr", 2'd3, 32'd0);
        exp_lookups = 0;
        exp_updates = 0;
        exp_misses  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bp.fetch_bpredictor_lookup = 1'b1;
        run_init("reinit");
        bp.fetch_bpredictor_lookup = 1'b0;
        lookup_chk("t6_post", 32'h200, 1'b0, 1'b0, mk_meta(8'h00, 10'h080, 1'b0));
        check_dbg("t6_lookups", 2'd0, 32'(exp_lookups));
        check_dbg("t6_updates", 2'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
